// File: rtl/jk_counter_pkg.sv
// Shared definitions for the jk_counter block: mode encodings used by the RTL and its bench.
package jk_counter_pkg;

    localparam logic [1:0] MODE_HOLD_ENC = 2'b00;
    localparam logic [1:0] MODE_UP_ENC   = 2'b01;
    localparam logic [1:0] MODE_DOWN_ENC = 2'b10;
    localparam logic [1:0] MODE_LOAD_ENC = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD = MODE_HOLD_ENC,
        MODE_UP   = MODE_UP_ENC,
        MODE_DOWN = MODE_DOWN_ENC,
        MODE_LOAD = MODE_LOAD_ENC
    } mode_t;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop bit with complementary registered outputs and synchronous active-low reset.
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    // NOTE: state registers use non-blocking assignments so every cell samples pre-edge values;
    // reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= 1'b0;
            qbar <= 1'b1;
        end else begin
            case ({j, k})
                2'b01: begin
                    q    <= 1'b0;
                    qbar <= 1'b1;
                end
                2'b10: begin
                    q    <= 1'b1;
                    qbar <= 1'b0;
                end
                2'b11: begin
                    q    <= ~q;
                    qbar <= ~qbar;
                end
                default: begin
                    q    <= q;
                    qbar <= qbar;
                end
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Up/down/load modulus counter built from a bank of JK cells driven in toggle form.
// Build option: define JK_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module jk_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap
);

    localparam int             CW      = WIDTH + 1;
    localparam logic [CW-1:0]  MOD_EXT = CW'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    mode_t            mode_e;
    logic [CW-1:0]    q_ext;
    logic [CW-1:0]    d_ext;
    logic [CW-1:0]    inc_ext;
    logic [CW-1:0]    dec_ext;
    logic             up_edge;
    logic             down_edge;
    logic [WIDTH-1:0] next_q;
    logic             wrap_next;
    logic [WIDTH-1:0] toggle;

    assign mode_e = mode_t'(mode);
    assign q_ext  = {1'b0, q};
    assign d_ext  = {1'b0, d};

    // One extra bit lets MODULUS = 2**WIDTH be compared directly; the top bit of the
    // decrement is the borrow that marks the step below zero.
    assign inc_ext   = q_ext + CW'(1);
    assign dec_ext   = q_ext - CW'(1);
    assign up_edge   = (inc_ext == MOD_EXT);
    assign down_edge = dec_ext[WIDTH];

    // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        next_q    = q;
        wrap_next = 1'b0;
        if (en) begin
            case (mode_e)
                MODE_UP: begin
                    if (up_edge) begin
`ifdef JK_COUNTER_SAT_EN
                        next_q = q;
`else
                        next_q = '0;
`endif
                        wrap_next = 1'b1;
                    end else begin
                        next_q = inc_ext[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (down_edge) begin
`ifdef JK_COUNTER_SAT_EN
                        next_q = q;
`else
                        next_q = MAX_Q;
`endif
                        wrap_next = 1'b1;
                    end else begin
                        next_q = dec_ext[WIDTH-1:0];
                    end
                end
                MODE_LOAD: begin
                    next_q = (d_ext >= MOD_EXT) ? MAX_Q : d;
                end
                default: begin
                    next_q = q;
                end
            endcase
        end
    end

    // Toggle form: a bit flips exactly where the current and next values differ.
    assign toggle = q ^ next_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .j    (toggle[i]),
            .k    (toggle[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule
